mem_port_arbiter: RTL and testbench

//   Shares one single-ported memory bus between the pipeline's instruction-fetch (IF) port and

---
 rtl/mem_port_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported memory bus between the instruction-fetch (IF) and
//   data-memory (DM) ports of the core using a req/ready handshake.
//
//   Arbitration:
//     - DM normally wins.
//     - A streak counter forces an IF grant after MAX_DSTREAK consecutive DM
//       grants while a fetch is pending.
//
//   Acks:
//     - Acks are combinational in the completing cycle.
//     - The requester presents its next request (or drops req) in that same
//       cycle, which allows back-to-back transactions with no idle bubble.
//
//   Optional feature (macro MEMARB_TIMEOUT_EN):
//     - A busy counter aborts a transaction after TIMEOUT_CYCLES wait cycles.
//     - The aborted port gets a zero-data ack, and arb_err_o sets sticky.
//     - Without the macro, arb_err_o is tied to 0.
//
// Ports:
//   clk_i, reset_i                  clock, synchronous active-high reset
//   if_req_i, if_addr_i             fetch request / word address
//   if_rdata_o, if_ack_o            fetch data / one-cycle completion (comb)
//   if_stall_o                      if_req_i & ~if_ack_o
//   dm_req_i, dm_we_i, dm_addr_i,
//   dm_wdata_i                      data request / write / address / wdata
//   dm_rdata_o, dm_ack_o            data read data / completion (comb)
//   dm_stall_o                      dm_req_i & ~dm_ack_o
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o         registered memory bus request
//   mem_rdata_i, mem_ready_i        memory read data / completion
//   arb_err_o                       sticky timeout flag
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned MAX_DSTREAK    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_rdata_o,
   output logic        if_ack_o,
   output logic        if_stall_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   output logic [31:0] dm_rdata_o,
   output logic        dm_ack_o,
   output logic        dm_stall_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ready_i,
   output logic        arb_err_o
);

   localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);
   localparam int unsigned BW = 16;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BUSY_I = 2'd1,
      S_BUSY_D = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;

   logic busy_c, tmo_c, done_c, decide_c, dm_wins_c, grant_d_c, grant_i_c;

   // Byte-offset bits of the word addresses are not used.
   logic [3:0] unused_addr_lsb;
   assign unused_addr_lsb = {if_addr_i[1:0], dm_addr_i[1:0]};

   // Transaction ends on mem_ready (or timeout); a grant decision is made then or in IDLE.
   assign busy_c    = (state_q != S_IDLE);
   assign done_c    = busy_c && (mem_ready_i || tmo_c);
   assign decide_c  = (state_q == S_IDLE) || done_c;
   assign dm_wins_c = dm_req_i && (!if_req_i || (streak_q < SW'(MAX_DSTREAK)));
   assign grant_d_c = decide_c && dm_wins_c;
   assign grant_i_c = decide_c && !dm_wins_c && if_req_i;

`ifdef MEMARB_TIMEOUT_EN
   logic [BW-1:0] busy_cnt_q, busy_cnt_d;
   logic          arb_err_q, arb_err_d;

   // Counter value equals the number of wait cycles seen since the grant.
   assign tmo_c = busy_c && !mem_ready_i && (busy_cnt_q == BW'(TIMEOUT_CYCLES));

   // Busy counter and sticky error next-state.
   always_comb begin
      busy_cnt_d = busy_cnt_q;
      arb_err_d  = arb_err_q | tmo_c;
      if (decide_c) begin
         busy_cnt_d = '0;
      end else if (busy_c) begin
         busy_cnt_d = busy_cnt_q + BW'(1);
      end
   end

   // Timeout state registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         busy_cnt_q <= '0;
         arb_err_q  <= 1'b0;
      end else begin
         busy_cnt_q <= busy_cnt_d;
         arb_err_q  <= arb_err_d;
      end
   end

   assign arb_err_o = arb_err_q;
`else
   logic [BW-1:0] unused_timeout;
   assign unused_timeout = BW'(TIMEOUT_CYCLES);
   assign tmo_c          = 1'b0;
   assign arb_err_o      = 1'b0;
`endif

   // State and memory-bus registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         streak_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Next-state: grant latches the winner onto the bus; no grant returns to IDLE.
   always_comb begin
      state_d     = state_q;
      streak_d    = streak_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      if (decide_c) begin
         if (grant_d_c) begin
            state_d     = S_BUSY_D;
            mem_req_d   = 1'b1;
            mem_we_d    = dm_we_i;
            mem_addr_d  = {dm_addr_i[31:2], 2'b00};
            mem_wdata_d = dm_wdata_i;
         end else if (grant_i_c) begin
            state_d    = S_BUSY_I;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = {if_addr_i[31:2], 2'b00};
         end else begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
         end
      end

      // Streak only counts DM grants that actually delay a pending fetch.
      if (!if_req_i || grant_i_c) begin
         streak_d = '0;
      end else if (grant_d_c && (streak_q < SW'(MAX_DSTREAK))) begin
         streak_d = streak_q + SW'(1);
      end
   end

   // Outputs: acks and read data pass through in the completing cycle; gated by reset.
   always_comb begin
      if_ack_o   = 1'b0;
      dm_ack_o   = 1'b0;
      if_rdata_o = '0;
      dm_rdata_o = '0;
      if (!reset_i && done_c) begin
         if (state_q == S_BUSY_I) begin
            if_ack_o = 1'b1;
            if (mem_ready_i) if_rdata_o = mem_rdata_i;
         end
         if (state_q == S_BUSY_D) begin
            dm_ack_o = 1'b1;
            if (mem_ready_i) dm_rdata_o = mem_rdata_i;
         end
      end
      if_stall_o = if_req_i & ~if_ack_o;
      dm_stall_o = dm_req_i & ~dm_ack_o;
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter.
//
//   Structure:
//     - A per-cycle vector table covers: reset, single DM/IF transactions,
//       DM-before-IF ordering, wait states and reset mid-transaction.
//     - Hand-written sequences cover the fetch-starvation streak and the
//       timeout behaviour (with and without MEMARB_TIMEOUT_EN).
//
//   Timing:
//     - Inputs are driven 1 time unit after the rising edge.
//     - Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

`ifdef MEMARB_TIMEOUT_EN
   localparam int unsigned TMO = 8;
`else
   localparam int unsigned TMO = 64;
`endif

   localparam logic L = 1'b0;
   localparam logic H = 1'b1;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, if_ack, if_stall;
   logic [31:0] if_addr, if_rdata;
   logic        dm_req, dm_we, dm_ack, dm_stall;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        mem_req, mem_we, mem_ready, arb_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MAX_DSTREAK(4), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk), .reset_i(reset),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata),
      .if_ack_o(if_ack), .if_stall_o(if_stall),
      .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
      .dm_rdata_o(dm_rdata), .dm_ack_o(dm_ack), .dm_stall_o(dm_stall),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
      .arb_err_o(arb_err)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
   endtask

   // One row = one clock cycle of inputs and the outputs expected in that cycle.
   // ck[0]: check mem_we/mem_addr, ck[1]: check mem_wdata, ck[2]: check rdata.
   typedef struct {
      logic        rst, ifr;
      logic [31:0] ifa;
      logic        dmr, dmw;
      logic [31:0] dma, dmwd, mrd;
      logic        mrdy;
      logic        e_mreq, e_ifack, e_dmack, e_mwe;
      logic [31:0] e_maddr, e_mwd, e_rd;
      logic [2:0]  ck;
   } vec_t;

   localparam int NV = 19;
   vec_t tbl [NV];

   task automatic drive(input vec_t v);
      reset     = v.rst;
      if_req    = v.ifr;
      if_addr   = v.ifa;
      dm_req    = v.dmr;
      dm_we     = v.dmw;
      dm_addr   = v.dma;
      dm_wdata  = v.dmwd;
      mem_rdata = v.mrd;
      mem_ready = v.mrdy;
   endtask

   initial begin
      // reset, idle, ready ignored while IDLE
      tbl[0]  = '{H, L, 32'h0,   L, L, 32'h0,   32'h0,        32'h77777777, H,
                  L, L, L, L, 32'h0,   32'h0,        32'h0,        3'b111};
      // test 1: DM read of 0x100 (low address bits ignored), zero-wait memory
      tbl[1]  = '{L, L, 32'h0,   H, L, 32'h102, 32'h0,        32'h11111111, H,
                  L, L, L, L, 32'h0,   32'h0,        32'h0,        3'b011};
      tbl[2]  = '{L, L, 32'h0,   L, L, 32'h102, 32'h0,        32'hA5A50100, H,
                  H, L, H, L, 32'h100, 32'h0,        32'hA5A50100, 3'b111};
      tbl[3]  = '{L, L, 32'h0,   L, L, 32'h0,   32'h0,        32'h0,        L,
                  L, L, L, L, 32'h0,   32'h0,        32'h0,        3'b000};
      // test 2: IF and DM together from IDLE -> DM first, then IF with no gap
      tbl[4]  = '{L, H, 32'h400, H, H, 32'h204, 32'h12345678, 32'h0,        L,
                  L, L, L, L, 32'h0,   32'h0,        32'h0,        3'b000};
      tbl[5]  = '{L, H, 32'h400, L, H, 32'h204, 32'h12345678, 32'h0,        H,
                  H, L, H, H, 32'h204, 32'h12345678, 32'h0,        3'b011};
      tbl[6]  = '{L, H, 32'h400, L, H, 32'h0,   32'h0,        32'h0,        L,
                  H, L, L, L, 32'h400, 32'h0,        32'h0,        3'b001};
      tbl[7]  = '{L, L, 32'h400, L, L, 32'h0,   32'h0,        32'h0BADC0DE, H,
                  H, H, L, L, 32'h400, 32'h0,        32'h0BADC0DE, 3'b101};
      // test 4: DM write with 3 wait cycles, bus stable for 4 cycles
      tbl[8]  = '{L, L, 32'h0,   H, H, 32'h200, 32'hCAFEF00D, 32'h0,        L,
                  L, L, L, L, 32'h0,   32'h0,        32'h0,        3'b000};
      tbl[9]  = '{L, L, 32'h0,   H, H, 32'h200, 32'hCAFEF00D, 32'hFFFFFFFF, L,
                  H, L, L, H, 32'h200, 32'hCAFEF00D, 32'h0,        3'b011};
      tbl[10] = tbl[9];
      tbl[11] = tbl[9];
      tbl[12] = '{L, L, 32'h0,   L, H, 32'h200, 32'hCAFEF00D, 32'hFFFFFFFF, H,
                  H, L, H, H, 32'h200, 32'hCAFEF00D, 32'h0,        3'b011};
      // test 5: reset in BUSY_D while memory signals ready -> no ack, bus cleared
      tbl[13] = '{L, L, 32'h0,   H, L, 32'h300, 32'h0,        32'h0,        L,
                  L, L, L, L, 32'h0,   32'h0,        32'h0,        3'b000};
      tbl[14] = '{L, L, 32'h0,   H, L, 32'h300, 32'h0,        32'h0,        L,
                  H, L, L, L, 32'h300, 32'h0,        32'h0,        3'b011};
      tbl[15] = '{H, L, 32'h0,   H, L, 32'h300, 32'h0,        32'h55555555, H,
                  H, L, L, L, 32'h300, 32'h0,        32'h0,        3'b111};
      tbl[16] = '{L, L, 32'h0,   L, L, 32'h0,   32'h0,        32'h0,        H,
                  L, L, L, L, 32'h0,   32'h0,        32'h0,        3'b011};
      // single IF fetch of 0xB -> bus address 0x8, forced read
      tbl[17] = '{L, H, 32'hB,   L, L, 32'h0,   32'h0,        32'h0,        L,
                  L, L, L, L, 32'h0,   32'h0,        32'h0,        3'b000};
      tbl[18] = '{L, L, 32'hB,   L, L, 32'h0,   32'h0,        32'h13579BDF, H,
                  H, H, L, L, 32'h8,   32'h0,        32'h13579BDF, 3'b101};

      drive(tbl[0]);
      repeat (2) @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         @(posedge clk); #1;
         drive(tbl[i]);
         @(negedge clk);
         check($sformatf("v%0d mem_req", i),  32'(mem_req),  32'(tbl[i].e_mreq));
         check($sformatf("v%0d if_ack", i),   32'(if_ack),   32'(tbl[i].e_ifack));
         check($sformatf("v%0d dm_ack", i),   32'(dm_ack),   32'(tbl[i].e_dmack));
         check($sformatf("v%0d if_stall", i), 32'(if_stall), 32'(tbl[i].ifr & ~tbl[i].e_ifack));
         check($sformatf("v%0d dm_stall", i), 32'(dm_stall), 32'(tbl[i].dmr & ~tbl[i].e_dmack));
         check($sformatf("v%0d arb_err", i),  32'(arb_err),  32'h0);
         if (tbl[i].ck[0]) begin
            check($sformatf("v%0d mem_we", i),   32'(mem_we), 32'(tbl[i].e_mwe));
            check($sformatf("v%0d mem_addr", i), mem_addr,    tbl[i].e_maddr);
         end
         if (tbl[i].ck[1]) check($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].e_mwd);
         if (tbl[i].ck[2]) begin
            if (tbl[i].rst || tbl[i].e_ifack)
               check($sformatf("v%0d if_rdata", i), if_rdata, tbl[i].e_rd);
            if (tbl[i].rst || tbl[i].e_dmack)
               check($sformatf("v%0d dm_rdata", i), dm_rdata, tbl[i].e_rd);
         end
      end

      // Test 3: fetch held while DM issues 10 back-to-back accesses (zero-wait).
      begin
         logic exp_if [13];
         int n_if;
         int n_dm;
         exp_if = '{L, L, L, L, H, L, L, L, L, H, L, L, H};
         n_if = 0;
         n_dm = 0;
         @(posedge clk); #1;
         reset = L; if_req = H; if_addr = 32'h1000;
         dm_req = H; dm_we = L; dm_addr = 32'h2000; dm_wdata = 32'h0; mem_ready = H;
         for (int k = 0; k < 13; k++) begin
            @(posedge clk); #1;
            mem_rdata = 32'hD0000000 | 32'(k);
            @(negedge clk);
            if (exp_if[k]) begin
               check($sformatf("s3 k%0d ack", k), 32'({if_ack, dm_ack}), 32'h2);
               check($sformatf("s3 k%0d addr", k), mem_addr, 32'h1000 + 32'(4 * n_if));
               check($sformatf("s3 k%0d if_rdata", k), if_rdata, mem_rdata);
               n_if++;
               if_addr = 32'h1000 + 32'(4 * n_if);
               if (k == 12) if_req = L;
            end else begin
               check($sformatf("s3 k%0d ack", k), 32'({if_ack, dm_ack}), 32'h1);
               check($sformatf("s3 k%0d addr", k), mem_addr, 32'h2000 + 32'(4 * n_dm));
               check($sformatf("s3 k%0d dm_rdata", k), dm_rdata, mem_rdata);
               check($sformatf("s3 k%0d if_stall", k), 32'(if_stall), 32'h1);
               n_dm++;
               if (n_dm == 10) dm_req = L;
               else dm_addr = 32'h2000 + 32'(4 * n_dm);
            end
         end
         @(posedge clk); #1;
         @(negedge clk);
         check("s3 idle mem_req", 32'(mem_req), 32'h0);
      end

      // Memory that never answers: timeout abort, or wait forever without the feature.
      begin
         int got;
         int at;
         logic [31:0] rd;
         got = 0;
         at  = 0;
         rd  = 32'hX;
         @(posedge clk); #1;
         if_req = H; if_addr = 32'h40; dm_req = L; mem_ready = L; mem_rdata = 32'hFFFFFFFF;
         for (int c = 1; c <= int'(TMO) + 16; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (if_ack) begin
               got = 1;
               at  = c;
               rd  = if_rdata;
               if_req = L;
               break;
            end
         end
`ifdef MEMARB_TIMEOUT_EN
         check("tmo ack seen", 32'(got), 32'h1);
         check("tmo ack cycle", 32'(at), 32'(TMO + 1));
         check("tmo if_rdata", rd, 32'h0);
         for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("tmo arb_err c%0d", c), 32'(arb_err), 32'h1);
            check($sformatf("tmo mem_req c%0d", c), 32'(mem_req), 32'h0);
         end
`else
         check("wait ack none", 32'(got), 32'h0);
         check("wait mem_req", 32'(mem_req), 32'h1);
         check("wait mem_addr", mem_addr, 32'h40);
         check("wait arb_err", 32'(arb_err), 32'h0);
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
